// File: rtl/uart_rx_frontend_pkg.sv
// uart_rx_frontend_pkg: definitions shared by the UART receive front end and
// the debug-core decoder that sits downstream of it: default bit timing,
// debug opcodes and the receiver FSM state encoding.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state, 8E1).

`ifndef UART_CLKS_PER_BIT
`define UART_CLKS_PER_BIT 868
`endif

package uart_rx_frontend_pkg;

    // 100 MHz system clock, 115200 baud.
    localparam int unsigned DEFAULT_CLKS_PER_BIT = `UART_CLKS_PER_BIT;

    // Debug protocol opcodes, decoded downstream of this block.
    localparam logic [7:0] OP_PING    = 8'h01;
    localparam logic [7:0] OP_PAUSE   = 8'h02;
    localparam logic [7:0] OP_RESUME  = 8'h03;
    localparam logic [7:0] OP_NEXT    = 8'h04;
    localparam logic [7:0] OP_PROGRAM = 8'h05;
    localparam logic [7:0] OP_OK      = 8'h06;
    localparam logic [7:0] OP_SIGNAL  = 8'h07;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_GAP       = 3'd5,
        ST_WAIT_HIGH = 3'd6
    } rx_state_e;

endpackage

// File: rtl/uart_rx_frontend_if.sv
// uart_rx_frontend_if: valid/ready byte stream from the UART receiver to
// the opcode/program decoder. The receiver is the master (source).

interface uart_rx_frontend_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_frontend_byte_fifo.sv
// byte_fifo: synchronous first-word-fall-through FIFO. The head entry is
// visible on rd_data_o whenever the FIFO is non-empty (zero while empty).
// A push into a full FIFO succeeds only if a pop happens in the same cycle.

module byte_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Qualify requests and compute the next pointer/occupancy values.
    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and occupancy registers; pointers wrap at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write.
    // NOTE: the array is deliberately not reset; stale entries are never
    // visible because occupancy gates both the read data and the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: UART receiver feeding the debug-core decoder.
// Synchronises the raw line, deserialises LSB-first frames, buffers bytes
// in a FWFT FIFO and flags framing errors, overflow and end-of-burst idle.
// Build option: define UART_RX_PARITY_EN for 8E1 framing (default 8N1).

module uart_rx_frontend
    import uart_rx_frontend_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned CNT_WIDTH    = 10,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    uart_rx_frontend_if.master            rx_bus,
    output logic                          frame_gap,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_BIT_END  = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_HALF_END = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);

    logic                 sync1_q;
    logic                 rx_s_q;
    rx_state_e            state_q,   state_d;
    logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q,   shift_d;
    logic                 push_q,    push_d;
    logic                 gap_q,     gap_d;
    logic                 err_q,     err_d;
    logic                 ovf_q,     ovf_d;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad_q, parity_bad_d;
`endif

    logic                 fifo_full;
    logic                 fifo_empty;

    // Two-flop synchroniser on the asynchronous serial line; idles high.
    // NOTE: flops use non-blocking assignment so rx_s_q sees the old sync1_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            rx_s_q  <= sync1_q;
        end
    end

    // Next-state logic: bit timing, sampling and event generation.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_WIDTH'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        gap_d     = 1'b0;
        err_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = ST_START;
            end
            ST_START: begin
                // Mid-start-bit check rejects short glitches.
                if (cnt_q == CNT_HALF_END) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    bit_idx_d        = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                // Even parity: data bits plus parity bit must XOR to zero.
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d        = '0;
                    parity_bad_d = rx_s_q ^ (^shift_q);
                    state_d      = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                    end else if (parity_bad_q) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
`endif
                    end else begin
                        push_d  = 1'b1;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                // A new start bit before a full idle bit-time means the
                // burst continues, so no gap is reported.
                if (!rx_s_q) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end else if (cnt_q == CNT_BIT_END) begin
                    cnt_d   = '0;
                    gap_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_HIGH: begin
                // Held here through a break so it yields only one error.
                cnt_d = '0;
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Overflow: a completed byte meets a full FIFO that is not being popped.
    always_comb begin
        ovf_d = push_q & fifo_full & ~(rx_bus.rx_ready & ~fifo_empty);
    end

    // FSM, datapath and registered event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            push_q    <= 1'b0;
            gap_q     <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            push_q    <= push_d;
            gap_q     <= gap_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
`endif
        end
    end

    // The assembled byte stays in shift_q until the next frame's data
    // phase, so it is still intact in the push cycle.
    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_q),
        .push_data_i (shift_q),
        .pop_i       (rx_bus.rx_ready),
        .rd_data_o   (rx_bus.rx_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign rx_bus.rx_valid = ~fifo_empty;
    assign frame_gap       = gap_q;
    assign frame_err       = err_q;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed self-checking bench for uart_rx_frontend at
// CLKS_PER_BIT=16, FIFO_DEPTH=4. A table of single frames is applied in a
// loop; burst, overflow, break, pop-at-full and reset cases are hand-written.

module tb_uart_rx_frontend;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 16;
    logic parity_flip = 1'b0;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       frame_gap;
    logic       frame_err;
    logic       overflow;
    logic [2:0] fifo_count;

    uart_rx_frontend_if bus ();

    uart_rx_frontend #(
        .CLKS_PER_BIT (CPB),
        .CNT_WIDTH    (5),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .rx_bus     (bus),
        .frame_gap  (frame_gap),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int   gap_cnt = 0, err_cnt = 0, ovf_cnt = 0;
    int   rise_cyc = -1, gap_cyc = -1;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_gap) begin gap_cnt++; gap_cyc = cyc; end
            if (frame_err) err_cnt++;
            if (overflow)  ovf_cnt++;
            if (bus.rx_valid && !prev_valid) rise_cyc = cyc;
        end
        prev_valid = bus.rx_valid;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one full frame; d is the cycle in which the start bit begins.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int d);
        d = cyc;
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = (^b) ^ parity_flip;
        tick(CPB);
`endif
        uart_rx = stop_bit;
        tick(CPB);
        uart_rx = 1'b1;
    endtask

    task automatic pop_one();
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_push;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int d, g0, e0, o0;
        vecs[0] = '{8'h00, 1'b1, 1'b1};
        vecs[1] = '{8'hFF, 1'b1, 1'b1};
        vecs[2] = '{8'h5A, 1'b1, 1'b1};
        vecs[3] = '{8'h81, 1'b1, 1'b1};
        vecs[4] = '{8'hC3, 1'b0, 1'b0};
        vecs[5] = '{8'h3C, 1'b1, 1'b1};

        bus.rx_ready = 1'b0;
        rst = 1'b1;
        tick(3);
        check("reset rx_valid", bus.rx_valid, 0);
        check("reset fifo_count", fifo_count, 0);
        check("reset rx_data", bus.rx_data, 0);
        check("reset pulses", {frame_gap, frame_err, overflow}, 0);
        rst = 1'b0;
        tick(5);

        // Pop while empty is ignored.
        bus.rx_ready = 1'b1;
        tick(2);
        bus.rx_ready = 1'b0;
        check("empty pop count", fifo_count, 0);

        // Test 1: single byte timing.
        g0 = gap_cnt;
        send_frame(8'hA5, 1'b1, d);
        tick(CPB);
        check("t1 valid latency", rise_cyc - d, 156 + PB);
        check("t1 gap latency", gap_cyc - d, 171 + PB);
        check("t1 gap count", gap_cnt - g0, 1);
        check("t1 rx_data", bus.rx_data, 8'hA5);
        pop_one();
        check("t1 drained", bus.rx_valid, 0);

        // Table: single frames, good and bad stop bits.
        for (int i = 0; i < 6; i++) begin
            g0 = gap_cnt; e0 = err_cnt;
            send_frame(vecs[i].data, vecs[i].stop, d);
            tick(CPB);
            check($sformatf("vec%0d count", i), fifo_count, vecs[i].exp_push);
            check($sformatf("vec%0d data", i), bus.rx_data, vecs[i].exp_push ? vecs[i].data : 8'h00);
            check($sformatf("vec%0d err", i), err_cnt - e0, !vecs[i].exp_push);
            check($sformatf("vec%0d gap", i), gap_cnt - g0, vecs[i].exp_push);
            pop_one();
            check($sformatf("vec%0d empty", i), fifo_count, 0);
        end

        // Test 2: back-to-back bytes, gap only after the last.
        g0 = gap_cnt;
        send_frame(8'h03, 1'b1, d);
        send_frame(8'h07, 1'b1, d);
        tick(CPB);
        check("t2 count", fifo_count, 2);
        check("t2 gap count", gap_cnt - g0, 1);
        check("t2 head0", bus.rx_data, 8'h03);
        pop_one();
        check("t2 head1", bus.rx_data, 8'h07);
        pop_one();
        check("t2 valid", bus.rx_valid, 0);

        // Test 3: overflow on the fifth byte.
        o0 = ovf_cnt;
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, d);
        check("t3 no ovf at 4", ovf_cnt - o0, 0);
        send_frame(8'h14, 1'b1, d);
        tick(CPB);
        check("t3 ovf once", ovf_cnt - o0, 1);
        check("t3 count", fifo_count, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3 head%0d", i), bus.rx_data, 8'h10 + 8'(i));
            pop_one();
        end
        check("t3 drained", bus.rx_valid, 0);

        // Test 4: short glitch, then a long break.
        g0 = gap_cnt; e0 = err_cnt;
        uart_rx = 1'b0;
        tick(8);
        uart_rx = 1'b1;
        tick(3 * CPB);
        check("t4 glitch count", fifo_count, 0);
        check("t4 glitch events", (err_cnt - e0) + (gap_cnt - g0), 0);
        send_frame(8'h3C, 1'b1, d);
        tick(CPB);
        check("t4 post-glitch data", bus.rx_data, 8'h3C);
        pop_one();
        e0 = err_cnt;
        uart_rx = 1'b0;
        tick(30 * CPB);
        uart_rx = 1'b1;
        tick(2 * CPB);
        check("t4 break err", err_cnt - e0, 1);
        check("t4 break count", fifo_count, 0);

        // Test 5a: FIFO full, pop in the push cycle.
        for (int i = 0; i < 4; i++) send_frame(8'h21 + 8'(i), 1'b1, d);
        check("t5 full", fifo_count, 4);
        o0 = ovf_cnt;
        fork
            send_frame(8'h25, 1'b1, d);
            begin
                tick(155 + PB);
                bus.rx_ready = 1'b1;
                tick(1);
                bus.rx_ready = 1'b0;
            end
        join
        tick(CPB);
        check("t5 no ovf", ovf_cnt - o0, 0);
        check("t5 count", fifo_count, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5 head%0d", i), bus.rx_data, 8'h22 + 8'(i));
            pop_one();
        end

        // Test 5b: reset in the middle of the data phase.
        send_frame(8'h66, 1'b1, d);
        uart_rx = 1'b0;
        tick(60);
        rst = 1'b1;
        tick(1);
        check("t5 rst valid", bus.rx_valid, 0);
        check("t5 rst count", fifo_count, 0);
        check("t5 rst data", bus.rx_data, 0);
        check("t5 rst pulses", {frame_gap, frame_err, overflow}, 0);
        rst = 1'b0;
        uart_rx = 1'b1;
        tick(2 * CPB);
        send_frame(8'h99, 1'b1, d);
        tick(CPB);
        check("t5 post-rst count", fifo_count, 1);
        check("t5 post-rst data", bus.rx_data, 8'h99);
        pop_one();

`ifdef UART_RX_PARITY_EN
        // Test 6: even parity accept and reject.
        e0 = err_cnt;
        parity_flip = 1'b0;
        send_frame(8'h07, 1'b1, d);
        tick(CPB);
        check("t6 good parity data", bus.rx_data, 8'h07);
        check("t6 good parity err", err_cnt - e0, 0);
        pop_one();
        parity_flip = 1'b1;
        send_frame(8'h07, 1'b1, d);
        tick(CPB);
        parity_flip = 1'b0;
        check("t6 bad parity err", err_cnt - e0, 1);
        check("t6 bad parity count", fifo_count, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
